// File: rtl/frame_energy_reader.sv
// rtl/frame_energy_reader.sv - claims filled ping-pong buffers, drains one frame, reports energy and peak
// One result record per frame; the next buffer is not claimed until the current record is consumed.
module frame_energy_reader #(
  parameter int SAMPLE_W = 16,
  parameter int BUF_LEN  = 256,
  parameter int ACC_W    = 2*SAMPLE_W + $clog2(BUF_LEN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                buf_ready_i,
  input  logic                buf_id_i,
  output logic                buf_take_o,
  input  logic [SAMPLE_W-1:0] rd_data_i,
  input  logic                rd_valid_i,
  output logic                rd_ready_o,
  input  logic                rd_last_i,
  output logic [ACC_W-1:0]    res_energy_o,
  output logic [SAMPLE_W-1:0] res_peak_o,
  output logic                res_buf_id_o,
  output logic                res_len_err_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                frame_drop_o,
  output logic                busy_o
);

  localparam int CNT_W = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUF_LEN - 1);

  typedef enum logic [1:0] {IDLE, TAKE, WAIT, STREAM} state_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  pend_id_q, pend_id_d;
  logic                  frame_id_q, frame_id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [SAMPLE_W-1:0]   peak_q, peak_d;
  logic [ACC_W-1:0]      res_energy_q, res_energy_d;
  logic [SAMPLE_W-1:0]   res_peak_q, res_peak_d;
  logic                  res_id_q, res_id_d;
  logic                  res_err_q, res_err_d;
  logic                  res_valid_q, res_valid_d;
  logic                  take_q, take_d;
  logic                  ready_q, ready_d;
  logic                  drop_q, drop_d;
  logic                  busy_q, busy_d;

  logic signed [SAMPLE_W-1:0]   x;
  logic signed [2*SAMPLE_W-1:0] sq;
  logic [2*SAMPLE_W-1:0]        sq_u;
  logic [SAMPLE_W-1:0]          abs_x;
  logic [ACC_W-1:0]             acc_nx;
  logic [SAMPLE_W-1:0]          peak_nx;
  logic                         beat;
  logic                         at_last;
  logic                         frame_end;

  always_comb begin
    x       = $signed(rd_data_i);
    sq      = x * x;
    sq_u    = sq;
    // Negating the most negative sample yields 2^(SAMPLE_W-1), still exact as unsigned.
    abs_x   = rd_data_i[SAMPLE_W-1] ? (~rd_data_i + 1'b1) : rd_data_i;
    acc_nx  = acc_q + ACC_W'(sq_u);
    peak_nx = (abs_x > peak_q) ? abs_x : peak_q;
    beat      = rd_valid_i && ready_q;
    at_last   = (cnt_q == CNT_LAST);
    frame_end = beat && (rd_last_i || at_last);

    state_d      = state_q;
    pending_d    = pending_q;
    pend_id_d    = pend_id_q;
    frame_id_d   = frame_id_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    peak_d       = peak_q;
    res_energy_d = res_energy_q;
    res_peak_d   = res_peak_q;
    res_id_d     = res_id_q;
    res_err_d    = res_err_q;
    res_valid_d  = res_valid_q;
    drop_d       = buf_ready_i && pending_q && !take_q;

    // A new buffer arriving on the take cycle becomes the next pending one.
    if (buf_ready_i) begin
      pending_d = 1'b1;
      pend_id_d = buf_id_i;
    end else if (take_q) begin
      pending_d = 1'b0;
    end

    if (res_valid_q && res_ready_i) begin
      res_valid_d  = 1'b0;
      res_energy_d = '0;
      res_peak_d   = '0;
      res_id_d     = 1'b0;
      res_err_d    = 1'b0;
    end

    case (state_q)
      IDLE: if (pending_q && !res_valid_q) state_d = TAKE;
      TAKE: begin
        cnt_d      = '0;
        acc_d      = '0;
        peak_d     = '0;
        frame_id_d = pend_id_q;
        state_d    = WAIT;
      end
      WAIT: if (rd_valid_i) state_d = STREAM;
      STREAM: begin
        if (beat) begin
          acc_d  = acc_nx;
          peak_d = peak_nx;
          cnt_d  = cnt_q + 1'b1;
        end
        if (frame_end) begin
          res_energy_d = acc_nx;
          res_peak_d   = peak_nx;
          res_id_d     = frame_id_q;
          res_err_d    = rd_last_i ^ at_last;
          res_valid_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    take_d  = (state_d == TAKE);
    ready_d = (state_d == STREAM);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      pend_id_q    <= 1'b0;
      frame_id_q   <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      peak_q       <= '0;
      res_energy_q <= '0;
      res_peak_q   <= '0;
      res_id_q     <= 1'b0;
      res_err_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      take_q       <= 1'b0;
      ready_q      <= 1'b0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pend_id_q    <= pend_id_d;
      frame_id_q   <= frame_id_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      peak_q       <= peak_d;
      res_energy_q <= res_energy_d;
      res_peak_q   <= res_peak_d;
      res_id_q     <= res_id_d;
      res_err_q    <= res_err_d;
      res_valid_q  <= res_valid_d;
      take_q       <= take_d;
      ready_q      <= ready_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  assign buf_take_o    = take_q;
  assign rd_ready_o    = ready_q;
  assign res_energy_o  = res_energy_q;
  assign res_peak_o    = res_peak_q;
  assign res_buf_id_o  = res_id_q;
  assign res_len_err_o = res_err_q;
  assign res_valid_o   = res_valid_q;
  assign frame_drop_o  = drop_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_frame_energy_reader.sv
// tb/tb_frame_energy_reader.sv - scoreboard bench for frame_energy_reader
module tb_frame_energy_reader;
  localparam int SW = 16;
  localparam int BL = 256;
  localparam int AW = 2*SW + $clog2(BL);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          buf_ready_i = 1'b0;
  logic          buf_id_i = 1'b0;
  logic          buf_take_o;
  logic [SW-1:0] rd_data_i = '0;
  logic          rd_valid_i = 1'b0;
  logic          rd_ready_o;
  logic          rd_last_i = 1'b0;
  logic [AW-1:0] res_energy_o;
  logic [SW-1:0] res_peak_o;
  logic          res_buf_id_o;
  logic          res_len_err_o;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic          frame_drop_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  frame_energy_reader #(.SAMPLE_W(SW), .BUF_LEN(BL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .buf_ready_i(buf_ready_i), .buf_id_i(buf_id_i),
    .buf_take_o(buf_take_o), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
    .rd_ready_o(rd_ready_o), .rd_last_i(rd_last_i), .res_energy_o(res_energy_o),
    .res_peak_o(res_peak_o), .res_buf_id_o(res_buf_id_o), .res_len_err_o(res_len_err_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .frame_drop_o(frame_drop_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [63:0] energy;
    logic [63:0] peak;
    logic        id;
    logic        err;
  } rec_t;

  rec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   takes = 0;
  int   drops = 0;
  int   smp[BL];
  bit   gaps = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    rec_t r;
    if (!rst_i) begin
      if (buf_take_o) takes++;
      if (frame_drop_o) drops++;
      if (res_valid_o && res_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          r = sb.pop_front();
          check("energy", 64'(res_energy_o), r.energy);
          check("peak", 64'(res_peak_o), r.peak);
          check("buf_id", 64'(res_buf_id_o), 64'(r.id));
          check("len_err", 64'(res_len_err_o), 64'(r.err));
        end
      end
    end
  end

  // Expected record for a frame whose rd_last sits at index last_at (-1: never asserted).
  task automatic push_exp(input bit id, input int last_at, output int n_beats);
    rec_t   r;
    longint e = 0;
    longint p = 0;
    longint a;
    int     end_idx = (last_at >= 0 && last_at < BL-1) ? last_at : BL-1;
    for (int i = 0; i <= end_idx; i++) begin
      e += longint'(smp[i]) * longint'(smp[i]);
      a = (smp[i] < 0) ? -longint'(smp[i]) : longint'(smp[i]);
      if (a > p) p = a;
    end
    r.energy = 64'(e);
    r.peak   = 64'(p);
    r.id     = id;
    r.err    = (last_at != BL-1);
    sb.push_back(r);
    n_beats = end_idx + 1;
  endtask

  task automatic announce(input bit id);
    @(negedge clk_i);
    buf_ready_i = 1'b1;
    buf_id_i    = id;
    @(negedge clk_i);
    buf_ready_i = 1'b0;
  endtask

  task automatic wait_take();
    int n = 0;
    while (!buf_take_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("take_seen", 64'(buf_take_o), 64'd1);
  endtask

  task automatic stream(input int n_beats, input int last_at);
    int i = 0;
    int guard = 0;
    while (i < n_beats && guard < 4000) begin
      @(negedge clk_i);
      guard++;
      if (gaps && $urandom_range(0, 4) == 0) begin
        rd_valid_i = 1'b0;
      end else begin
        rd_valid_i = 1'b1;
        rd_data_i  = SW'(smp[i]);
        rd_last_i  = (i == last_at);
        if (rd_ready_o) i++;
      end
    end
    @(negedge clk_i);
    rd_valid_i = 1'b0;
    rd_last_i  = 1'b0;
    check("beats_delivered", 64'(i), 64'(n_beats));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic frame(input bit id, input int last_at);
    int nb;
    push_exp(id, last_at, nb);
    announce(id);
    wait_take();
    stream(nb, last_at);
    wait_drain();
    @(negedge clk_i);
    check("idle_after_frame", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int nb;
    int t0;
    int d0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_outputs", 64'({buf_take_o, rd_ready_o, res_energy_o, res_peak_o, res_buf_id_o,
                                res_len_err_o, res_valid_o, frame_drop_o, busy_o}), 64'd0);

    for (int i = 0; i < BL; i++) smp[i] = 1000;
    frame(1'b0, BL-1);
    check("single_take", 64'(takes), 64'd1);

    gaps = 1'b1;
    for (int i = 0; i < BL; i++) smp[i] = i - 128;
    frame(1'b1, BL-1);

    for (int i = 0; i < BL; i++) smp[i] = -32768;
    frame(1'b0, BL-1);

    // Held result blocks the next claim; a superseding buffer is dropped.
    res_ready_i = 1'b0;
    for (int i = 0; i < BL; i++) smp[i] = $urandom_range(0, 65535) - 32768;
    push_exp(1'b1, BL-1, nb);
    announce(1'b1);
    wait_take();
    stream(nb, BL-1);
    repeat (3) @(negedge clk_i);
    check("result_held", 64'(res_valid_o), 64'd1);
    t0 = takes;
    d0 = drops;
    announce(1'b0);
    repeat (20) @(negedge clk_i);
    check("no_take_while_held", 64'(takes), 64'(t0));
    check("no_drop_first", 64'(drops), 64'(d0));
    announce(1'b1);
    repeat (5) @(negedge clk_i);
    check("drop_once", 64'(drops), 64'(d0 + 1));
    check("still_no_take", 64'(takes), 64'(t0));
    for (int i = 0; i < BL; i++) smp[i] = $urandom_range(0, 65535) - 32768;
    push_exp(1'b1, BL-1, nb);
    res_ready_i = 1'b1;
    wait_take();
    stream(nb, BL-1);
    wait_drain();

    for (int i = 0; i < BL; i++) smp[i] = (i % 7) * 300 - 900;
    frame(1'b0, 99);
    frame(1'b1, -1);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < BL; i++) smp[i] = 77;
    announce(1'b0);
    wait_take();
    stream(50, -1);
    check("busy_before_reset", 64'(busy_o), 64'd1);
    #2 rst_i = 1'b1;
    #1 check("async_reset_outputs", 64'({buf_take_o, rd_ready_o, res_energy_o, res_peak_o,
         res_buf_id_o, res_len_err_o, res_valid_o, frame_drop_o, busy_o}), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < BL; i++) smp[i] = 2 * i - 255;
    frame(1'b1, BL-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
